// File: rtl/keypad_key_fifo.sv
// rtl/keypad_key_fifo.sv - debounced keypad press qualifier feeding a show-ahead key FIFO
// Define KEY_REPEAT_EN to add auto-repeat pushes while a key stays held.
module keypad_key_fifo #(
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY  = 64,
  parameter int unsigned REPEAT_RATE   = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [3:0]               Code,
  input  logic                     Valid,
  input  logic                     rd_en,
  output logic [3:0]               out_code,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     key_held
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(STABLE_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_QUALIFY, ST_HELD, ST_RELEASE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cand_q, cand_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            press_push;
  logic            rep_push;
  logic            push;

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    press_push = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Valid) begin
          state_d = ST_QUALIFY;
          cand_d  = Code;
          cnt_d   = CW'(1);
        end
      end
      ST_QUALIFY: begin
        if (!Valid) begin
          state_d = ST_IDLE;
        end else if (Code != cand_q) begin
          cand_d = Code;
          cnt_d  = CW'(1);
        end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
          press_push = 1'b1;
          state_d    = ST_HELD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HELD: begin
        if (!Valid) begin
          state_d = ST_RELEASE;
          cnt_d   = CW'(1);
        end
      end
      ST_RELEASE: begin
        if (!Valid) begin
          if (cnt_q == CW'(STABLE_CYCLES - 1)) state_d = ST_IDLE;
          else                                  cnt_d   = cnt_q + CW'(1);
        end else if (Code == cand_q) begin
          state_d = ST_HELD;
        end else begin
          state_d = ST_QUALIFY;
          cand_d  = Code;
          cnt_d   = CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef KEY_REPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_DELAY + 1);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;

  // After each repeat the counter reloads so the next hit lands REPEAT_RATE
  // cycles later; assumes 1 <= REPEAT_RATE <= REPEAT_DELAY.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    rep_push  = 1'b0;
    if (state_q != ST_HELD) begin
      rep_cnt_d = '0;
    end else if (Valid) begin
      if (rep_cnt_q == RW'(REPEAT_DELAY)) begin
        rep_push  = 1'b1;
        rep_cnt_d = RW'(REPEAT_DELAY - REPEAT_RATE + 1);
      end else begin
        rep_cnt_d = rep_cnt_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) rep_cnt_q <= '0;
    else        rep_cnt_q <= rep_cnt_d;
  end
`else
  logic unused_repeat_params;
  assign unused_repeat_params = ^{REPEAT_DELAY, REPEAT_RATE};
  assign rep_push = 1'b0;
`endif

  assign push = press_push | rep_push;

  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          overflow_q;
  logic          pop, full, do_push;

  assign pop     = rd_en && (count_q != '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_push = push && (!full || pop);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cand_q     <= 4'h0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (push && full && !pop) overflow_q <= 1'b1;
    end
  end

  // Storage needs no reset: the head is masked whenever count is zero.
  always_ff @(posedge clock) begin
    if (reset && do_push) mem_q[wr_ptr_q] <= cand_q;
  end

  assign out_valid = (count_q != '0);
  assign out_code  = out_valid ? mem_q[rd_ptr_q] : 4'h0;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign key_held  = (state_q == ST_HELD) || (state_q == ST_RELEASE);

endmodule
